// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end: PC generator, single-outstanding-request
// instruction-memory handshake (tolerates multi-cycle latency) and a
// DEPTH-entry prefetch FIFO of {instr, pc+2} feeding the IF/ID latch.
// Handles redirect flush (with drain of an in-flight request), decode
// back-pressure and HALT.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   -> a word returning while the FIFO is empty in FETCH is shown on
//                id_* in the same cycle (and only written if decode stalls).
//   undefined -> no bypass; done-to-id_valid latency is one cycle.
//
// Parameters
//   WIDTH     instruction / address width
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//   RESET_PC  fetch address after reset
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   imem_addr / imem_rd      request address / read strobe to instruction memory
//   imem_data / imem_done    returned word / completion strobe
//   redirect / redirect_pc   taken branch/jump: flush and refetch from redirect_pc
//   halt                     stop fetching once the in-flight request finishes
//   id_stall                 decode cannot accept this cycle
//   id_valid/id_instr/id_pc2 head instruction and its address + 2
//   count                    FIFO occupancy
//   err                      sticky: imem_done seen without imem_rd
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [WIDTH-1:0]       imem_addr,
  output logic                   imem_rd,
  input  logic [WIDTH-1:0]       imem_data,
  input  logic                   imem_done,
  input  logic                   redirect,
  input  logic [WIDTH-1:0]       redirect_pc,
  input  logic                   halt,
  input  logic                   id_stall,
  output logic                   id_valid,
  output logic [WIDTH-1:0]       id_instr,
  output logic [WIDTH-1:0]       id_pc2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [AW:0]      FULL    = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(2);

  typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_HALT} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_fetch_pc, w_fetch_pc_next;
  logic [WIDTH-1:0] r_drain_addr, w_drain_addr_next;
  logic             r_halt_pend, w_halt_pend_next;
  logic [AW-1:0]    r_rd_ptr, r_wr_ptr;
  logic [AW:0]      r_count;
  logic             r_err;

  logic [WIDTH-1:0] r_mem_instr [DEPTH];
  logic [WIDTH-1:0] r_mem_pc2   [DEPTH];

  logic             w_fifo_valid, w_fetch_done, w_outstanding;
  logic             w_bypass, w_push, w_pop;
  logic [WIDTH-1:0] w_pc2;

  // Memory request side. A request in FETCH is only issued with a free slot;
  // while it waits nothing can be pushed, so imem_rd and imem_addr stay put.
  always_comb begin
    imem_rd   = 1'b0;
    imem_addr = r_fetch_pc;
    case (r_state)
      S_FETCH: imem_rd = !rst && (r_count != FULL);
      S_DRAIN: begin
        imem_rd   = !rst;
        imem_addr = r_drain_addr;
      end
      default: imem_rd = 1'b0;
    endcase
  end

  assign w_pc2         = r_fetch_pc + PC_STEP;
  assign w_fifo_valid  = (r_count != '0);
  assign w_fetch_done  = (r_state == S_FETCH) && imem_rd && imem_done;
  assign w_outstanding = imem_rd && !imem_done;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_fetch_done && !w_fifo_valid && !redirect;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word that decode takes immediately never enters the FIFO.
  // Redirect clears the FIFO, which also voids any pop in that cycle.
  assign w_push = w_fetch_done && !redirect && !(w_bypass && !id_stall);
  assign w_pop  = w_fifo_valid && !id_stall && !redirect;

  assign id_valid = w_fifo_valid || w_bypass;
  assign count    = r_count;
  assign err      = r_err;

  always_comb begin
    id_instr = '0;
    id_pc2   = '0;
    if (w_bypass) begin
      id_instr = imem_data;
      id_pc2   = w_pc2;
    end else if (w_fifo_valid) begin
      id_instr = r_mem_instr[r_rd_ptr];
      id_pc2   = r_mem_pc2[r_rd_ptr];
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next      = r_state;
    w_fetch_pc_next   = r_fetch_pc;
    w_drain_addr_next = r_drain_addr;
    w_halt_pend_next  = r_halt_pend;
    if (redirect) begin
      // Redirect overrides halt. An in-flight request cannot be withdrawn,
      // so its address is held in DRAIN until memory answers.
      w_fetch_pc_next  = redirect_pc;
      w_halt_pend_next = 1'b0;
      if (w_outstanding) begin
        w_state_next      = S_DRAIN;
        w_drain_addr_next = imem_addr;
      end else begin
        w_state_next = S_FETCH;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_fetch_done) w_fetch_pc_next = w_pc2;
          if (halt || r_halt_pend) begin
            if (w_outstanding) begin
              w_halt_pend_next = 1'b1;
            end else begin
              w_halt_pend_next = 1'b0;
              w_state_next     = S_HALT;
            end
          end
        end
        S_DRAIN: begin
          if (halt) w_halt_pend_next = 1'b1;
          if (imem_done) begin
            w_state_next     = (halt || r_halt_pend) ? S_HALT : S_FETCH;
            w_halt_pend_next = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_fetch_pc   <= RESET_PC;
      r_drain_addr <= '0;
      r_halt_pend  <= 1'b0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_fetch_pc   <= w_fetch_pc_next;
      r_drain_addr <= w_drain_addr_next;
      r_halt_pend  <= w_halt_pend_next;
      if (redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
      r_err <= r_err || (imem_done && !imem_rd);
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= imem_data;
      r_mem_pc2[r_wr_ptr]   <= w_pc2;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue. A small memory model answers requests after
// a programmable number of wait cycles (word = f(address)). Expected
// {instr, pc2} pairs are queued as each scenario is set up; a negedge monitor
// pops and compares whenever decode consumes a word.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_rd;
  logic [WIDTH-1:0] imem_data;
  logic             imem_done;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             halt;
  logic             id_stall;
  logic             id_valid;
  logic [WIDTH-1:0] id_instr;
  logic [WIDTH-1:0] id_pc2;
  logic [2:0]       count;
  logic             err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .imem_data  (imem_data),
    .imem_done  (imem_done),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .id_stall   (id_stall),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc2     (id_pc2),
    .count      (count),
    .err        (err)
  );

  // ---------------- memory model ----------------
  int         lat;
  logic       force_done;
  logic [3:0] wait_cnt;

  function automatic logic [15:0] prog(input logic [15:0] a);
    return ((a >> 1) + 16'd1) * 16'h1111;
  endfunction

  always @(posedge clk) begin
    if (rst || !imem_rd || imem_done) wait_cnt <= 4'd0;
    else                              wait_cnt <= wait_cnt + 4'd1;
  end

  assign imem_done = force_done || (imem_rd && (int'(wait_cnt) >= lat));
  assign imem_data = prog(imem_addr);

  // ---------------- checking ----------------
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic expect_word(input logic [15:0] a);
    exp_q.push_back({prog(a), a + 16'd2});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && id_valid && !id_stall && !redirect) begin
      if (exp_q.size() == 0) begin
        chk("pop_while_empty", 32'(id_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("consume instr=%h pc2=%h", id_instr, id_pc2);
        chk("id_instr", 32'(id_instr), 32'(mon_e[31:16]));
        chk("id_pc2", 32'(id_pc2), 32'(mon_e[15:0]));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    id_stall = 1'b0; force_done = 1'b0; lat = 0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_imem_rd", 32'(imem_rd), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_id_instr", 32'(id_instr), 32'd0);
    chk("rst_id_pc2", 32'(id_pc2), 32'd0);
    step();

    // Zero-wait stream from RESET_PC, halted after 8 words
    rst = 1'b0;
    for (int i = 0; i < 8; i++) expect_word(16'(2 * i));
    for (int i = 0; i < 10; i++) begin
      halt = (i == 7);
      @(negedge clk);
      if (i < 8) begin
        chk("stream_rd", 32'(imem_rd), 32'd1);
        chk("stream_addr", 32'(imem_addr), 32'(2 * i));
      end else begin
        chk("stream_halted_rd", 32'(imem_rd), 32'd0);
      end
      chk("stream_count_le1", 32'(count <= 3'd1), 32'd1);
      if (i == 0) chk("first_id_valid", 32'(id_valid), 32'(BYP));
      if (i == 1) chk("second_id_valid", 32'(id_valid), 32'd1);
      step();
    end
    halt = 1'b0;
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure: restart at 0 with decode stalled
    redirect = 1'b1; redirect_pc = 16'h0000; id_stall = 1'b1;
    for (int i = 0; i < 5; i++) expect_word(16'(2 * i));
    step();
    redirect = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("bp_count", 32'(count), 32'(j < 4 ? j : 4));
      chk("bp_rd", 32'(imem_rd), 32'(j < 4));
      step();
    end
    id_stall = 1'b0;
    @(negedge clk);
    chk("bp_full_count", 32'(count), 32'd4);
    chk("bp_full_rd", 32'(imem_rd), 32'd0);
    step();
    halt = 1'b1;
    @(negedge clk);
    chk("bp_resume_rd", 32'(imem_rd), 32'd1);
    chk("bp_resume_addr", 32'(imem_addr), 32'h0008);
    step();
    halt = 1'b0;
    repeat (5) step();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_count_end", 32'(count), 32'd0);

    // Multi-cycle memory (done on the third cycle of each request), then halt
    lat = 2;
    redirect = 1'b1; redirect_pc = 16'h0020;
    for (int i = 0; i < 3; i++) expect_word(16'(16'h0020 + 2 * i));
    step();
    redirect = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      halt = (c == 7);
      @(negedge clk);
      if (c <= 9) begin
        chk("mc_rd", 32'(imem_rd), 32'd1);
        chk("mc_addr", 32'(imem_addr), 32'(16'h0020 + 2 * ((c - 1) / 3)));
      end else begin
        chk("halt_rd_low", 32'(imem_rd), 32'd0);
      end
      step();
    end
    halt = 1'b0;
    chk("mc_drained", 32'(exp_q.size()), 32'd0);

    // Redirect while a request is waiting: drain 0x0010, refetch 0x0040
    redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    expect_word(16'h0040);
    for (int c = 1; c <= 8; c++) begin
      redirect = (c == 2); redirect_pc = 16'h0040;
      halt = (c == 4);
      @(negedge clk);
      if (c <= 3) begin
        chk("drain_rd", 32'(imem_rd), 32'd1);
        chk("drain_addr", 32'(imem_addr), 32'h0010);
      end else if (c <= 6) begin
        chk("redir_rd", 32'(imem_rd), 32'd1);
        chk("redir_addr", 32'(imem_addr), 32'h0040);
      end else begin
        chk("redir_halt_rd", 32'(imem_rd), 32'd0);
      end
      if (c == 3) chk("drain_id_valid", 32'(id_valid), 32'd0);
      step();
    end
    redirect = 1'b0; halt = 1'b0;
    chk("redir_drained", 32'(exp_q.size()), 32'd0);

    // halt + redirect in the same cycle while fetching: redirect wins
    lat = 0;
    redirect = 1'b1; redirect_pc = 16'h0060;
    step();
    redirect = 1'b0; id_stall = 1'b1;
    @(negedge clk);
    chk("hr_addr_60", 32'(imem_addr), 32'h0060);
    step();
    redirect = 1'b1; redirect_pc = 16'h0080; halt = 1'b1;
    @(negedge clk);
    chk("hr_count_before", 32'(count), 32'd1);
    step();
    expect_word(16'h0080);
    redirect = 1'b0; halt = 1'b1; id_stall = 1'b0;
    @(negedge clk);
    chk("hr_rd", 32'(imem_rd), 32'd1);
    chk("hr_addr_80", 32'(imem_addr), 32'h0080);
    chk("hr_count_flushed", 32'(count), 32'd0);
    step();
    halt = 1'b0;
    @(negedge clk);
    chk("hr_halted_rd", 32'(imem_rd), 32'd0);
    step();
    step();
    chk("hr_drained", 32'(exp_q.size()), 32'd0);

    // Protocol error: done while no request (in HALT)
    @(negedge clk);
    chk("err_before", 32'(err), 32'd0);
    step();
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("err_sticky", 32'(err), 32'd1);
      step();
    end
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("err_cleared", 32'(err), 32'd0);
    chk("final_count", 32'(count), 32'd0);
    chk("final_rd_in_rst", 32'(imem_rd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
